// File: rtl/register_file_scoreboard.sv
// Register file: two combinational read ports, one write port (1-cycle latency), optional write bypass,
// and a per-register busy scoreboard; issue_ready holds off WAW reservations on already-busy registers.
module register_file_scoreboard #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter bit BYPASS      = 1'b1,
  parameter int DEBUG_INDEX = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs_index,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic                  rs_busy,
  input  logic [ADDR_WIDTH-1:0] rt_index,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic                  rt_busy,
  input  logic [ADDR_WIDTH-1:0] rd_index,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_index,
  output logic                  issue_ready,
  output logic [ADDR_WIDTH:0]   pending_count,
  output logic [DATA_WIDTH-1:0] debug_data,
  output logic                  error
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [ADDR_WIDTH:0]   pend_q;
  logic                  err_q;

  logic issue_acc;
  logic same_idx_issue;
  logic cnt_inc;
  logic cnt_dec;
  logic wb_err;

  assign issue_ready    = !reset && ((issue_index == '0) || !busy[issue_index] ||
                                     (write_enable && (rd_index == issue_index)));
  assign issue_acc      = issue_valid && issue_ready;
  assign same_idx_issue = issue_acc && (issue_index == rd_index);

  // A reservation that lands on a register being written back this edge keeps it busy.
  assign cnt_inc = issue_acc && (issue_index != '0) && !busy[issue_index];
  assign cnt_dec = write_enable && (rd_index != '0) && busy[rd_index] && !same_idx_issue;
  assign wb_err  = write_enable && ((rd_index == '0) || (!busy[rd_index] && !same_idx_issue));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy   <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (write_enable && (rd_index != '0)) regs[rd_index] <= rd_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (issue_acc && (issue_index == ADDR_WIDTH'(i)))
          busy[i] <= 1'b1;
        else if (write_enable && (rd_index == ADDR_WIDTH'(i)))
          busy[i] <= 1'b0;
      end
      pend_q <= pend_q + (ADDR_WIDTH+1)'(cnt_inc) - (ADDR_WIDTH+1)'(cnt_dec);
      if (wb_err) err_q <= 1'b1;
    end
  end

  always_comb begin
    rs_data = regs[rs_index];
    if (BYPASS && write_enable && (rd_index == rs_index)) rs_data = rd_data;
    if (reset || (rs_index == '0)) rs_data = '0;

    rt_data = regs[rt_index];
    if (BYPASS && write_enable && (rd_index == rt_index)) rt_data = rd_data;
    if (reset || (rt_index == '0)) rt_data = '0;
  end

  assign rs_busy = !reset && busy[rs_index] && !(BYPASS && write_enable && (rd_index == rs_index));
  assign rt_busy = !reset && busy[rt_index] && !(BYPASS && write_enable && (rd_index == rt_index));

  assign pending_count = pend_q;
  assign error         = err_q;
  assign debug_data    = reset ? '0 : regs[ADDR_WIDTH'(DEBUG_INDEX)];

endmodule
